// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the instruction encoder: format codes, base opcodes,
// FSM state encoding and the combinational field packer.
package instr_encoder_pkg;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ISH = 3'd6,
      FMT_RSV = 3'd7
   } fmt_e;

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Branch/jump offsets must be halfword aligned; reserved formats never encode.
   function automatic logic beat_dropped(input fmt_e fmt, input logic imm_lsb);
      return (fmt == FMT_RSV) || (((fmt == FMT_B) || (fmt == FMT_J)) && imm_lsb);
   endfunction

   function automatic logic [31:0] encode(
      input fmt_e        fmt,
      input logic [6:0]  opcode,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [2:0]  funct3,
      input logic [6:0]  funct7,
      input logic [31:0] imm
   );
      logic [31:0] w;
      w = '0;
      case (fmt)
         FMT_R:   w = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I:   w = {imm[11:0], rs1, funct3, rd, opcode};
         FMT_ISH: w = {funct7, imm[4:0], rs1, funct3, rd, opcode};
         FMT_S:   w = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         FMT_U:   w = {imm[31:12], rd, opcode};
         FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         default: w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Encoded-word buffer: DEPTH x 32 circular FIFO with an extra pointer bit
// to tell full from empty. Head word is presented combinationally.
module enc_fifo #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_i,
   input  logic [31:0] wdata_i,
   input  logic        pop_i,
   output logic [31:0] rdata_o,
   output logic        full_o,
   output logic        empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0] mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_i && !full_o) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i && !empty_o) rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/instr_encoder.sv
// Session-based instruction encoder: packs instruction fields into 32-bit
// words, buffers them and streams them to instruction memory by byte address.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_LOAD  | accepting instruction beats until in_last
// ST_DRAIN | no more input; emptying the buffer to memory
// ST_DONE  | one-cycle completion pulse
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] count
);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic              err_q, err_d;
   logic              fifo_full, fifo_empty;
   logic [31:0]       fifo_rdata, enc_word;
   logic              start_acc, accept, dropped, push, pop;

   assign start_acc = (state_q == ST_IDLE) && start;
   assign in_ready  = (state_q == ST_LOAD) && !fifo_full;
   assign accept    = in_valid && in_ready;
   assign dropped   = beat_dropped(fmt_e'(in_fmt), in_imm[0]);
   assign push      = accept && !dropped;
   assign enc_word  = encode(fmt_e'(in_fmt), in_opcode, in_rd, in_rs1, in_rs2,
                             in_funct3, in_funct7, in_imm);

   // The FIFO head is the write port, so a stalled write holds naturally.
   assign wr_valid  = !fifo_empty;
   assign pop       = wr_valid && wr_ready;
   assign wr_data   = wr_valid ? fifo_rdata : '0;
   assign wr_addr   = wr_addr_q;
   assign count     = count_q;
   assign err       = err_q;
   assign busy      = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);

   enc_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (enc_word),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_LOAD;
         ST_LOAD:  if (accept && in_last) state_d = ST_DRAIN;
         ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_addr_d = wr_addr_q;
      count_d   = count_q;
      err_d     = err_q;
      if (start_acc) begin
         wr_addr_d = base_addr;
         count_d   = '0;
         err_d     = 1'b0;
      end else begin
         if (pop) begin
            wr_addr_d = wr_addr_q + ADDR_W'(4);
            count_d   = count_q + ADDR_W'(1);
         end
         if (accept && dropped) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wr_addr_q <= '0;
         count_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_addr_q <= wr_addr_d;
         count_q   <= count_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: stimulus pushes hand-computed writes into
// a scoreboard queue, a negedge monitor compares every presented write.
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst, start, in_valid, in_last, wr_ready;
   logic [AW-1:0] base_addr;
   logic [2:0]    in_fmt, in_funct3;
   logic [6:0]    in_opcode, in_funct7;
   logic [4:0]    in_rd, in_rs1, in_rs2;
   logic [31:0]   in_imm;
   logic          in_ready, wr_valid, busy, done, err;
   logic [AW-1:0] wr_addr, count;
   logic [31:0]   wr_data;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t           exp_q[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [AW-1:0] exp_addr;
   int            exp_count;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(AW), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err(err), .count(count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Stalled writes are compared every cycle, which also covers hold stability.
   always @(negedge clk) begin
      if (rst === 1'b0 && wr_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h, expected no write",
                     wr_addr, wr_data);
         end else begin
            check("wr_addr", 32'(wr_addr), 32'(exp_q[0].addr));
            check("wr_data", wr_data, exp_q[0].data);
            if (wr_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic start_session(input logic [AW-1:0] base);
      start     = 1'b1;
      base_addr = base;
      @(posedge clk); #1;
      start     = 1'b0;
      exp_addr  = base;
      exp_count = 0;
      check("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm, input logic last,
                       input logic good, input logic [31:0] exp);
      logic r;
      int   n;
      n = 0;
      r = 1'b0;
      in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         r = in_ready;
         @(posedge clk); #1;
         n++;
      end while (!r && n < 100);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!r) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got no in_ready in %0d cycles, expected acceptance", n);
      end else if (good) begin
         exp_q.push_back('{addr: exp_addr, data: exp});
         exp_addr = exp_addr + AW'(4);
         exp_count++;
      end
   endtask

   task automatic finish_session(input logic exp_err);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (done !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout: got done=%b after %0d cycles, expected 1", done, n);
      end else begin
         check("count_at_done", 32'(count), 32'(exp_count));
         check("err_at_done", 32'(err), 32'(exp_err));
         check("queue_drained", 32'(exp_q.size()), 32'd0);
         @(posedge clk); #1;
         check("done_one_cycle", 32'(done), 32'd0);
         check("busy_after_done", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
      in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_funct3 = '0; in_funct7 = '0; in_imm = '0; wr_ready = 1'b1;
      exp_addr = '0; exp_count = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_wr_valid", 32'(wr_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // basic: addi x1,x0,5 ; add x3,x1,x2
      start_session(10'h100);
      send(FMT_I, OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 1'b1, 32'h00500093);
      send(FMT_R, OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 1'b1, 32'h002081B3);
      finish_session(1'b0);

      // remaining formats: sw, beq -4, lui, srai, jal 8
      start_session(10'h200);
      send(FMT_S,   OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0,    32'd8,         1'b0, 1'b1, 32'h0020A423);
      send(FMT_B,   OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,    32'hFFFFFFFC,  1'b0, 1'b1, 32'hFE208EE3);
      send(FMT_U,   OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0,    32'h12345000,  1'b0, 1'b1, 32'h123452B7);
      send(FMT_ISH, OP_I,      5'd1, 5'd2, 5'd0, 3'd5, 7'h20,   32'd3,         1'b0, 1'b1, 32'h40315093);
      send(FMT_J,   OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'd8,         1'b1, 1'b1, 32'h008000EF);
      finish_session(1'b0);

      // backpressure: 4 fill the buffer, the 5th waits for wr_ready
      wr_ready = 1'b0;
      start_session(10'h000);
      for (int k = 1; k <= 4; k++)
         send(FMT_I, OP_I, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k), 1'b0, 1'b1,
              (32'(k) << 20) | (32'(k) << 7) | 32'h13);
      @(negedge clk);
      check("in_ready_full", 32'(in_ready), 32'd0);
      check("wr_valid_stalled", 32'(wr_valid), 32'd1);
      @(posedge clk); #1;
      fork
         begin
            send(FMT_I, OP_I, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 1'b1, 32'h00500293);
            send(FMT_I, OP_I, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 1'b1, 1'b1, 32'h00600313);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            check("queue_held_during_stall", 32'(exp_q.size()), 32'd4);
            wr_ready = 1'b1;
         end
      join
      finish_session(1'b0);

      // error: misaligned branch and reserved format dropped, then a good word
      start_session(10'h040);
      send(FMT_B,   OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b0, 1'b0, 32'd0);
      send(FMT_RSV, OP_R,      5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      check("err_sticky", 32'(err), 32'd1);
      send(FMT_I, OP_I, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b1, 1'b1, 32'h00100393);
      finish_session(1'b1);
      start_session(10'h080);
      check("err_cleared_on_start", 32'(err), 32'd0);
      check("count_cleared_on_start", 32'(count), 32'd0);
      // dropped last word with empty buffer: DRAIN then DONE
      send(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b1, 1'b0, 32'd0);
      check("drain_cycle_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      check("done_two_cycles", 32'(done), 32'd1);
      check("err_dropped_last", 32'(err), 32'd1);
      check("count_dropped_last", 32'(count), 32'd0);
      @(posedge clk); #1;

      // wrap: 0x3FC then 0x000
      start_session(10'h3FC);
      send(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0, 1'b1, 32'h123452B7);
      send(FMT_I, OP_I,   5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        1'b1, 1'b1, 32'h00500093);
      finish_session(1'b0);
      check("wr_addr_after_wrap", 32'(wr_addr), 32'h004);

      // reset mid-session with 3 words buffered
      wr_ready = 1'b0;
      start_session(10'h100);
      for (int k = 1; k <= 3; k++)
         send(FMT_I, OP_I, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k), 1'b0, 1'b1,
              (32'(k) << 20) | (32'(k) << 7) | 32'h13);
      check("buffered_before_rst", 32'(wr_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      rst = 1'b0;
      wr_ready = 1'b1;
      check("busy_after_rst", 32'(busy), 32'd0);
      check("count_after_rst", 32'(count), 32'd0);
      check("wr_addr_after_rst", 32'(wr_addr), 32'd0);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("no_write_after_rst", 32'(wr_valid), 32'd0);
      end
      start_session(10'h300);
      send(FMT_I, OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 1'b1, 32'h00500093);
      finish_session(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
